// File: rtl/uart_pkg.sv
// Shared definitions for the UART message transmitter: FSM state encoding,
// common ASCII constants and elaboration-time helper functions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_NEXT,
    ST_GAP
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned pow;
    res = 0;
    pow = 1;
    while (pow < value) begin
      pow = pow << 1;
      res = res + 1;
    end
    return res;
  endfunction

  // Clock cycles per UART bit, rounded to nearest.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// UART frame serializer: start bit, 8 data bits LSB first, STOP_BITS stop bits,
// each bit held CLK_DIV cycles.
// Ports: clk, rst_n; load/data start a frame; tx is the registered serial line
// (idle high); last_c flags the final cycle of the last stop bit.
module uart_tx_shift
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       last_c
);

  localparam int unsigned NBITS = 9 + STOP_BITS;
  localparam int unsigned SW    = NBITS - 1;
  localparam int unsigned BW    = clog2(CLK_DIV);
  localparam int unsigned NW    = clog2(NBITS);

  logic          active_q, active_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [NW-1:0] bit_q, bit_d;
  logic [SW-1:0] sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          bit_end_c;

  // Baud/bit counting; the shift register holds data then stop bits.
  always_comb begin
    active_d  = active_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    bit_end_c = active_q && (baud_q == BW'(CLK_DIV - 1));
    last_c    = bit_end_c && (bit_q == NW'(NBITS - 1));
    if (load) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      sh_d     = {{STOP_BITS{1'b1}}, data};
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (bit_end_c) begin
        baud_d = '0;
        if (last_c) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d = bit_q + NW'(1);
          tx_d  = sh_q[0];
          sh_d  = {1'b1, sh_q[SW-1:1]};
        end
      end else begin
        baud_d = baud_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '1;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/uart_msg_tx.sv
// Host-loadable UART message sender with single-shot/repeat modes and
// one-entry echo insertion of received bytes between message bytes.
// Ports: SYSCLK/RST_B; START/STOP_REQ/MODE/MSG_LEN control a pass;
// WE/WADDR/WDATA write the message buffer; ECHO_EN/RX_VALID/RX_DATA feed the
// echo slot; UART_TX_O serial line, BUSY, DONE and ECHO_DROP status.
module uart_msg_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned MSG_DEPTH  = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned GAP_CYCLES = 1000
) (
  input  logic                      SYSCLK,
  input  logic                      RST_B,
  input  logic                      START,
  input  logic                      STOP_REQ,
  input  logic                      MODE,
  input  logic [clog2(MSG_DEPTH):0] MSG_LEN,
  input  logic                      WE,
  input  logic [clog2(MSG_DEPTH)-1:0] WADDR,
  input  logic [7:0]                WDATA,
  input  logic                      ECHO_EN,
  input  logic                      RX_VALID,
  input  logic [7:0]                RX_DATA,
  output logic                      UART_TX_O,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ECHO_DROP
);

  localparam int unsigned AW = clog2(MSG_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = clog2(GAP_CYCLES + 1);

  state_e        state_q, state_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic          mode_q, mode_d;
  logic          msg_act_q, msg_act_d;     // a message pass (not a lone echo) is running
  logic          sent_echo_q, sent_echo_d; // frame in flight carries an echo byte
  logic          start_pend_q, start_pend_d;
  logic          stop_pend_q, stop_pend_d;
  logic          echo_full_q, echo_full_d;
  logic [7:0]    echo_byte_q, echo_byte_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;

  logic          load_c;
  logic [7:0]    load_byte_c;
  logic          echo_take_c;
  logic          echo_rdy_c;
  logic          stop_any_c;
  logic [LW-1:0] idx_inc_c;
  logic          last_c;

  logic [7:0]    msg_mem [MSG_DEPTH];

  // Message buffer, writable at any time; not reset.
  always_ff @(posedge SYSCLK) begin
    if (WE) msg_mem[WADDR] <= WDATA;
  end

  // Next-state, echo slot and status logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    mode_d       = mode_q;
    msg_act_d    = msg_act_q;
    sent_echo_d  = sent_echo_q;
    start_pend_d = start_pend_q;
    gap_d        = gap_q;
    done_d       = 1'b0;
    load_c       = 1'b0;
    load_byte_c  = msg_mem[idx_q[AW-1:0]];
    echo_take_c  = 1'b0;
    echo_rdy_c   = echo_full_q & ECHO_EN;
    stop_any_c   = stop_pend_q | STOP_REQ;
    idx_inc_c    = idx_q + (sent_echo_q ? LW'(0) : LW'(1));

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          mode_d = MODE;
          len_d  = MSG_LEN;
          if (MSG_LEN == '0) begin
            done_d       = 1'b1;
            start_pend_d = 1'b0;
          end else begin
            start_pend_d = 1'b1;
          end
        end
        // A waiting echo goes first; the start request stays held behind it.
        if (echo_rdy_c) begin
          state_d   = ST_LOAD;
          msg_act_d = 1'b0;
        end else if (start_pend_d) begin
          state_d      = ST_LOAD;
          msg_act_d    = 1'b1;
          start_pend_d = 1'b0;
          idx_d        = '0;
        end
      end
      ST_LOAD: begin
        load_c  = 1'b1;
        state_d = ST_SHIFT;
        if (echo_rdy_c) begin
          load_byte_c = echo_byte_q;
          echo_take_c = 1'b1;
          sent_echo_d = 1'b1;
        end else begin
          sent_echo_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (last_c) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (!msg_act_q) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_inc_c;
          if (idx_inc_c == len_q) begin
            done_d = 1'b1;
            if (mode_q && !stop_any_c) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (STOP_REQ) begin
          state_d = ST_IDLE;
        end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    stop_pend_d = (state_d == ST_IDLE) ? 1'b0 : stop_any_c;

    // A new byte arriving on the consuming cycle refills the slot without loss.
    echo_full_d = echo_full_q & ~echo_take_c;
    echo_byte_d = echo_byte_q;
    drop_d      = 1'b0;
    if (!ECHO_EN) begin
      echo_full_d = 1'b0;
    end else if (RX_VALID) begin
      echo_byte_d = RX_DATA;
      echo_full_d = 1'b1;
      drop_d      = echo_full_q & ~echo_take_c;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      mode_q       <= 1'b0;
      msg_act_q    <= 1'b0;
      sent_echo_q  <= 1'b0;
      start_pend_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      echo_full_q  <= 1'b0;
      echo_byte_q  <= '0;
      gap_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      msg_act_q    <= msg_act_d;
      sent_echo_q  <= sent_echo_d;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
      echo_full_q  <= echo_full_d;
      echo_byte_q  <= echo_byte_d;
      gap_q        <= gap_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
    end
  end

  uart_tx_shift #(
    .CLK_DIV  (CLK_DIV),
    .STOP_BITS(STOP_BITS)
  ) u_shift (
    .clk   (SYSCLK),
    .rst_n (RST_B),
    .load  (load_c),
    .data  (load_byte_c),
    .tx    (UART_TX_O),
    .last_c(last_c)
  );

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ECHO_DROP = drop_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Self-checking bench for uart_msg_tx: a line decoder turns the serial output
// back into bytes, and each scenario compares against the byte order and
// pulse counts expected from the message/echo rules.
module tb_uart_msg_tx;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned MSG_DEPTH  = 16;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned GAP_CYCLES = 10;
  localparam int unsigned FRAME      = (9 + STOP_BITS) * CLK_DIV;
  localparam int unsigned PERIOD     = FRAME + GAP_CYCLES + 2;

  logic       SYSCLK = 1'b0;
  logic       RST_B = 1'b0;
  logic       START = 1'b0;
  logic       STOP_REQ = 1'b0;
  logic       MODE = 1'b0;
  logic [4:0] MSG_LEN = '0;
  logic       WE = 1'b0;
  logic [3:0] WADDR = '0;
  logic [7:0] WDATA = '0;
  logic       ECHO_EN = 1'b0;
  logic       RX_VALID = 1'b0;
  logic [7:0] RX_DATA = '0;
  logic       UART_TX_O;
  logic       BUSY;
  logic       DONE;
  logic       ECHO_DROP;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  uart_msg_tx #(
    .CLK_DIV   (CLK_DIV),
    .MSG_DEPTH (MSG_DEPTH),
    .STOP_BITS (STOP_BITS),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .SYSCLK   (SYSCLK),
    .RST_B    (RST_B),
    .START    (START),
    .STOP_REQ (STOP_REQ),
    .MODE     (MODE),
    .MSG_LEN  (MSG_LEN),
    .WE       (WE),
    .WADDR    (WADDR),
    .WDATA    (WDATA),
    .ECHO_EN  (ECHO_EN),
    .RX_VALID (RX_VALID),
    .RX_DATA  (RX_DATA),
    .UART_TX_O(UART_TX_O),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ECHO_DROP(ECHO_DROP)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Line decoder and pulse counters, sampled on the falling edge.
  logic [7:0]  rx_q[$];
  int unsigned done_t[$];
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned drop_cnt = 0;
  int unsigned frame_err = 0;
  bit          in_frame = 1'b0;
  int unsigned fcnt = 0;
  int unsigned bitn = 0;
  logic [7:0]  sh = '0;

  always @(negedge SYSCLK) begin
    cyc++;
    if (!RST_B) begin
      in_frame = 1'b0;
    end else begin
      if (DONE === 1'b1) begin
        done_cnt++;
        done_t.push_back(cyc);
      end
      if (ECHO_DROP === 1'b1) drop_cnt++;
      if (!in_frame) begin
        if (UART_TX_O === 1'b0) begin
          in_frame = 1'b1;
          fcnt = 0;
        end
      end else begin
        fcnt++;
      end
      if (in_frame && (fcnt % CLK_DIV) == CLK_DIV / 2) begin
        bitn = fcnt / CLK_DIV;
        if (bitn == 0) begin
          if (UART_TX_O !== 1'b0) begin
            frame_err++;
            in_frame = 1'b0;
          end
        end else if (bitn <= 8) begin
          sh[bitn-1] = UART_TX_O;
        end else begin
          if (UART_TX_O !== 1'b1) frame_err++;
          rx_q.push_back(sh);
          in_frame = 1'b0;
        end
      end
    end
  end

  function automatic logic [7:0] rx_at(input int idx);
    if (idx < rx_q.size()) return rx_q[idx];
    return 8'hxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge SYSCLK);
    #1;
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    WE = 1'b1; WADDR = 4'(addr); WDATA = data;
    tick(1);
    WE = 1'b0;
  endtask

  task automatic go(input logic mode, input int len);
    START = 1'b1; MODE = mode; MSG_LEN = 5'(len);
    tick(1);
    START = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] data);
    RX_VALID = 1'b1; RX_DATA = data;
    tick(1);
    RX_VALID = 1'b0;
  endtask

  task automatic wait_line_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge SYSCLK);
      if (UART_TX_O === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Idle means BUSY low for several consecutive cycles.
  task automatic wait_quiet(input int budget, output bit ok);
    int q;
    q = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge SYSCLK);
      if (BUSY === 1'b0) q++;
      else q = 0;
      if (q >= 4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    tick(2);
    @(negedge SYSCLK);
    n_vec++; if (UART_TX_O !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", UART_TX_O); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_vec++; if (DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", DONE); end
    n_vec++; if (ECHO_DROP !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b want 0", ECHO_DROP); end
    tick(1);
    RST_B = 1'b1;
    tick(2);
  endtask

  task automatic test_hello;
    logic [7:0] hb;
    logic       exp_bit;
    logic       got_bit;
    bit         ok;
    int         base, d0, hi;
    hb = 8'h68;
    wr(0, 8'h68);
    wr(1, 8'h69);
    base = rx_q.size(); d0 = done_cnt;
    go(1'b0, 2);
    @(negedge SYSCLK);
    n_vec++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL hello_busy_rise: got %b want 1", BUSY); end
    wait_line_low(10, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL hello_start_bit: line never went low"); end
    for (int k = 0; k < 10; k++) begin
      ok = 1'b1;
      exp_bit = (k == 0) ? 1'b0 : (k <= 8) ? hb[k-1] : 1'b1;
      got_bit = exp_bit;
      for (int j = 0; j < int'(CLK_DIV); j++) begin
        if (k != 0 || j != 0) @(negedge SYSCLK);
        if (UART_TX_O !== exp_bit) begin ok = 1'b0; got_bit = UART_TX_O; end
      end
      n_vec++; if (!ok) begin n_err++; $display("FAIL hello_bit%0d: got %b want %b", k, got_bit, exp_bit); end
    end
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge SYSCLK);
      if (UART_TX_O === 1'b0) break;
      hi++;
    end
    n_vec++; if (hi != 2) begin n_err++; $display("FAIL hello_interframe: got %0d idle cycles want 2", hi); end
    wait_quiet(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL hello_timeout: BUSY stuck high"); end
    n_vec++; if (rx_at(base) !== 8'h68) begin n_err++; $display("FAIL hello_byte0: got %h want 68", rx_at(base)); end
    n_vec++; if (rx_at(base+1) !== 8'h69) begin n_err++; $display("FAIL hello_byte1: got %h want 69", rx_at(base+1)); end
    n_vec++; if (rx_q.size() != base + 2) begin n_err++; $display("FAIL hello_count: got %0d frames want 2", rx_q.size() - base); end
    n_vec++; if (done_cnt != d0 + 1) begin n_err++; $display("FAIL hello_done: got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_repeat;
    logic [7:0] b;
    bit ok;
    int base, d0, t0;
    b = 8'($urandom);
    wr(0, b);
    base = rx_q.size(); d0 = done_cnt; t0 = done_t.size();
    go(1'b1, 1);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge SYSCLK);
      if (done_cnt >= d0 + 3) begin ok = 1'b1; break; end
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL repeat_passes: got %0d DONE want 3", done_cnt - d0); end
    wait_line_low(80, ok);
    tick(10);
    STOP_REQ = 1'b1;
    tick(1);
    STOP_REQ = 1'b0;
    wait_quiet(300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL repeat_stop: still busy after STOP_REQ"); end
    n_vec++; if (done_cnt != d0 + 4) begin n_err++; $display("FAIL repeat_done: got %0d pulses want 4", done_cnt - d0); end
    n_vec++; if (rx_q.size() != base + 4) begin n_err++; $display("FAIL repeat_frames: got %0d want 4", rx_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (rx_at(base+i) !== b) begin n_err++; $display("FAIL repeat_byte%0d: got %h want %h", i, rx_at(base+i), b); end
    end
    for (int i = 0; i < 3; i++) begin
      if (done_t.size() > t0 + i + 1) begin
        n_vec++;
        if (done_t[t0+i+1] - done_t[t0+i] != PERIOD) begin
          n_err++; $display("FAIL repeat_period%0d: got %0d want %0d", i, done_t[t0+i+1] - done_t[t0+i], PERIOD);
        end
      end
    end
    tick(150);
    n_vec++; if (rx_q.size() != base + 4) begin n_err++; $display("FAIL repeat_after_stop: got %0d frames want 4", rx_q.size() - base); end
  endtask

  task automatic test_echo;
    logic [7:0] m [3];
    logic [7:0] exp_q[$];
    bit ok;
    int base, d0, p0;
    ECHO_EN = 1'b1;
    for (int i = 0; i < 3; i++) begin m[i] = 8'($urandom); wr(i, m[i]); end
    base = rx_q.size(); d0 = done_cnt; p0 = drop_cnt;
    go(1'b0, 3);
    wait_line_low(10, ok);
    tick(5);
    pulse_rx(8'h41);
    wait_quiet(400, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL echo_timeout: BUSY stuck high"); end
    exp_q = '{m[0], 8'h41, m[1], m[2]};
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (rx_at(base+i) !== exp_q[i]) begin n_err++; $display("FAIL echo_byte%0d: got %h want %h", i, rx_at(base+i), exp_q[i]); end
    end
    n_vec++; if (done_cnt != d0 + 1) begin n_err++; $display("FAIL echo_done: got %0d want 1", done_cnt - d0); end
    n_vec++; if (drop_cnt != p0) begin n_err++; $display("FAIL echo_nodrop: got %0d drops want 0", drop_cnt - p0); end
  endtask

  task automatic test_drop;
    logic [7:0] m [2];
    logic [7:0] exp_q[$];
    bit ok;
    int base, d0, p0;
    for (int i = 0; i < 2; i++) begin m[i] = 8'($urandom); wr(i, m[i]); end
    base = rx_q.size(); d0 = done_cnt; p0 = drop_cnt;
    go(1'b0, 2);
    wait_line_low(10, ok);
    tick(5);
    pulse_rx(8'h41);
    tick(8);
    pulse_rx(8'h42);
    wait_quiet(400, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL drop_timeout: BUSY stuck high"); end
    exp_q = '{m[0], 8'h42, m[1]};
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (rx_at(base+i) !== exp_q[i]) begin n_err++; $display("FAIL drop_byte%0d: got %h want %h", i, rx_at(base+i), exp_q[i]); end
    end
    n_vec++; if (rx_q.size() != base + 3) begin n_err++; $display("FAIL drop_count: got %0d frames want 3", rx_q.size() - base); end
    n_vec++; if (drop_cnt != p0 + 1) begin n_err++; $display("FAIL drop_pulse: got %0d want 1", drop_cnt - p0); end
    n_vec++; if (done_cnt != d0 + 1) begin n_err++; $display("FAIL drop_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_echo_idle;
    logic [7:0] e, e2;
    logic [7:0] m [2];
    logic [7:0] exp_q[$];
    bit ok;
    int base, d0, p0;
    e = 8'($urandom);
    base = rx_q.size(); d0 = done_cnt;
    pulse_rx(e);
    wait_quiet(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL idle_echo_timeout: BUSY stuck high"); end
    n_vec++; if (rx_at(base) !== e || rx_q.size() != base + 1) begin
      n_err++; $display("FAIL idle_echo_byte: got %h (%0d frames) want %h (1 frame)", rx_at(base), rx_q.size() - base, e);
    end
    n_vec++; if (done_cnt != d0) begin n_err++; $display("FAIL idle_echo_nodone: got %0d want 0", done_cnt - d0); end
    // Echo already waiting when START arrives: echo first, then the message.
    e2 = 8'($urandom);
    for (int i = 0; i < 2; i++) begin m[i] = 8'($urandom); wr(i, m[i]); end
    base = rx_q.size(); d0 = done_cnt; p0 = drop_cnt;
    RX_VALID = 1'b1; RX_DATA = e2;
    tick(1);
    RX_VALID = 1'b0;
    START = 1'b1; MODE = 1'b0; MSG_LEN = 5'd2;
    tick(1);
    START = 1'b0;
    wait_quiet(400, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL held_start_timeout: BUSY stuck high"); end
    exp_q = '{e2, m[0], m[1]};
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (rx_at(base+i) !== exp_q[i]) begin n_err++; $display("FAIL held_start_byte%0d: got %h want %h", i, rx_at(base+i), exp_q[i]); end
    end
    n_vec++; if (done_cnt != d0 + 1) begin n_err++; $display("FAIL held_start_done: got %0d want 1", done_cnt - d0); end
    n_vec++; if (drop_cnt != p0) begin n_err++; $display("FAIL held_start_nodrop: got %0d want 0", drop_cnt - p0); end
    ECHO_EN = 1'b0;
    tick(2);
  endtask

  task automatic test_zero_len;
    logic [7:0] m [2];
    bit ok, quiet;
    int base, d0;
    base = rx_q.size(); d0 = done_cnt;
    go(1'b0, 0);
    @(negedge SYSCLK);
    n_vec++; if (DONE !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", DONE); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b want 0", BUSY); end
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge SYSCLK);
      if (UART_TX_O !== 1'b1 || BUSY !== 1'b0) quiet = 1'b0;
    end
    n_vec++; if (!quiet) begin n_err++; $display("FAIL zero_line: got activity want idle"); end
    n_vec++; if (done_cnt != d0 + 1 || rx_q.size() != base) begin
      n_err++; $display("FAIL zero_counts: got %0d done %0d frames want 1 done 0 frames", done_cnt - d0, rx_q.size() - base);
    end
    // START while busy must be ignored (a repeat request here would never go idle).
    for (int i = 0; i < 2; i++) begin m[i] = 8'($urandom); wr(i, m[i]); end
    base = rx_q.size(); d0 = done_cnt;
    go(1'b0, 2);
    wait_line_low(10, ok);
    tick(3);
    go(1'b1, 1);
    wait_quiet(300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL busy_start_timeout: BUSY stuck high"); end
    n_vec++; if (rx_q.size() != base + 2 || rx_at(base) !== m[0] || rx_at(base+1) !== m[1]) begin
      n_err++; $display("FAIL busy_start_bytes: got %h %h (%0d frames) want %h %h", rx_at(base), rx_at(base+1), rx_q.size() - base, m[0], m[1]);
    end
    n_vec++; if (done_cnt != d0 + 1) begin n_err++; $display("FAIL busy_start_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_random;
    logic [7:0] m [MSG_DEPTH];
    logic [7:0] nv;
    bit ok;
    int len, base, d0;
    for (int it = 0; it < 4; it++) begin
      len = int'($urandom_range(2, MSG_DEPTH));
      for (int i = 0; i < len; i++) begin m[i] = 8'($urandom); wr(i, m[i]); end
      base = rx_q.size(); d0 = done_cnt;
      go(1'b0, len);
      wait_line_low(10, ok);
      // Entry 0 is already latched; the last entry has not been loaded yet.
      wr(0, 8'($urandom));
      nv = 8'($urandom);
      wr(len - 1, nv);
      m[len-1] = nv;
      wait_quiet(len * (int'(FRAME) + 2) + 100, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rand%0d_timeout: BUSY stuck high", it); end
      n_vec++; if (rx_q.size() != base + len) begin n_err++; $display("FAIL rand%0d_count: got %0d want %0d", it, rx_q.size() - base, len); end
      for (int i = 0; i < len; i++) begin
        n_vec++; if (rx_at(base+i) !== m[i]) begin n_err++; $display("FAIL rand%0d_byte%0d: got %h want %h", it, i, rx_at(base+i), m[i]); end
      end
      n_vec++; if (done_cnt != d0 + 1) begin n_err++; $display("FAIL rand%0d_done: got %0d want 1", it, done_cnt - d0); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] m [4];
    bit ok;
    int base;
    for (int i = 0; i < 4; i++) begin m[i] = 8'($urandom); wr(i, m[i]); end
    go(1'b0, 4);
    wait_line_low(10, ok);
    tick(6);
    RST_B = 1'b0;
    #1;
    n_vec++; if (UART_TX_O !== 1'b1) begin n_err++; $display("FAIL midreset_tx: got %b want 1", UART_TX_O); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", BUSY); end
    tick(3);
    RST_B = 1'b1;
    tick(2);
    base = rx_q.size();
    go(1'b0, 1);
    wait_quiet(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL midreset_timeout: BUSY stuck high"); end
    n_vec++; if (rx_q.size() != base + 1 || rx_at(base) !== m[0]) begin
      n_err++; $display("FAIL midreset_restart: got %h (%0d frames) want %h", rx_at(base), rx_q.size() - base, m[0]);
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_repeat();
    test_echo();
    test_drop();
    test_echo_idle();
    test_zero_len();
    test_random();
    test_reset_mid();
    n_vec++; if (frame_err != 0) begin n_err++; $display("FAIL framing: got %0d bad frames want 0", frame_err); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
